// File: rtl/video_ram_arbiter.sv
`default_nettype none
// video_ram_arbiter: shares one synchronous video RAM port between the CPU and the scanout fetcher.
// Rev 1.0 - initial release.
module video_ram_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 8,
    parameter int MAX_CPU_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWData,
    output logic [DATA_W-1:0] cpuRData,
    output logic              cpuAck,
    input  logic              vidReq,
    input  logic              vidUrgent,
    input  logic [ADDR_W-1:0] vidAddr,
    output logic [DATA_W-1:0] vidRData,
    output logic              vidAck,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramWe,
    output logic [DATA_W-1:0] ramWData,
    input  logic [DATA_W-1:0] ramRData
);
    localparam int               c_CNT_W   = $clog2(MAX_CPU_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_CPU_WAIT);

    logic                run_q;
    logic [c_CNT_W-1:0]  cpuWaitCnt_q, cpuWaitCnt_d;
    logic                cpuS1_q, cpuS2_q, vidS1_q, vidS2_q, wrS1_q, wrS2_q;
    logic                cpuAck_q, vidAck_q;
    logic [DATA_W-1:0]   cpuRData_q, vidRData_q;
    logic [ADDR_W-1:0]   ramAddr_q, ramAddr_d;
    logic                ramWe_q, ramWe_d;
    logic [DATA_W-1:0]   ramWData_q, ramWData_d;
    logic                w_cpuElig, w_vidElig, w_cpuWin, w_vidWin;

    // A requester with an access in the RAM or CAPTURE stage sits out arbitration.
    always_comb begin
        w_cpuElig = run_q & cpuReq & ~(cpuS1_q | cpuS2_q);
        w_vidElig = run_q & vidReq & ~(vidS1_q | vidS2_q);
        w_cpuWin  = w_cpuElig & (~w_vidElig | ((cpuWaitCnt_q >= c_MAX_CNT) & ~vidUrgent));
        w_vidWin  = w_vidElig & ~w_cpuWin;
    end

    always_comb begin
        cpuWaitCnt_d = cpuWaitCnt_q;
        if (!cpuReq || w_cpuWin) begin
            cpuWaitCnt_d = '0;
        end else if (w_cpuElig && (cpuWaitCnt_q < c_MAX_CNT)) begin
            cpuWaitCnt_d = cpuWaitCnt_q + c_CNT_W'(1);
        end
    end

    always_comb begin
        ramAddr_d  = ramAddr_q;
        ramWData_d = ramWData_q;
        ramWe_d    = 1'b0;
        if (w_cpuWin) begin
            ramAddr_d  = cpuAddr;
            ramWData_d = cpuWData;
            ramWe_d    = cpuWe;
        end else if (w_vidWin) begin
            ramAddr_d = vidAddr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q        <= 1'b0;
            cpuWaitCnt_q <= '0;
            cpuS1_q      <= 1'b0;
            cpuS2_q      <= 1'b0;
            vidS1_q      <= 1'b0;
            vidS2_q      <= 1'b0;
            wrS1_q       <= 1'b0;
            wrS2_q       <= 1'b0;
            cpuAck_q     <= 1'b0;
            vidAck_q     <= 1'b0;
            cpuRData_q   <= '0;
            vidRData_q   <= '0;
            ramAddr_q    <= '0;
            ramWe_q      <= 1'b0;
            ramWData_q   <= '0;
        end else begin
            run_q        <= 1'b1;
            cpuWaitCnt_q <= cpuWaitCnt_d;
            cpuS1_q      <= w_cpuWin;
            cpuS2_q      <= cpuS1_q;
            vidS1_q      <= w_vidWin;
            vidS2_q      <= vidS1_q;
            wrS1_q       <= w_cpuWin & cpuWe;
            wrS2_q       <= wrS1_q;
            cpuAck_q     <= cpuS2_q;
            vidAck_q     <= vidS2_q;
            ramAddr_q    <= ramAddr_d;
            ramWe_q      <= ramWe_d;
            ramWData_q   <= ramWData_d;
            // Write acks leave the CPU read register untouched.
            if (cpuS2_q && !wrS2_q) begin
                cpuRData_q <= ramRData;
            end
            if (vidS2_q) begin
                vidRData_q <= ramRData;
            end
        end
    end

    assign cpuRData = cpuRData_q;
    assign cpuAck   = cpuAck_q;
    assign vidRData = vidRData_q;
    assign vidAck   = vidAck_q;
    assign ramAddr  = ramAddr_q;
    assign ramWe    = ramWe_q;
    assign ramWData = ramWData_q;
endmodule
`default_nettype wire
